dmac_ahb_master_if: RTL and testbench
=====================================

Name: dmac_ahb_master_if

Overview:
- AHB-Lite master port shared downstream of the DMA channel datapath.
- Takes one burst request (address, direction, beat count, size) and drives the pipelined AHB address and data phases.
- Write data is popped from the channel FIFO (wdata_pop drives FIFO rd_en). Read data is pushed into the FIFO (rdata_valid drives FIFO wr_en).
- Reports done or error per burst to the channel controller.

Parameters:
- MAX_BEATS, 16, largest supported burst length; req_beats above this is clamped to it.
- ADDR_W, 32, address width.
- DATA_W, 32, data width; HSIZE above log2(DATA_W/8) is illegal.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  burst request
- req_ready  out  1  high only in IDLE; request accepted on req_valid&&req_ready
- req_write  in  1  1=write, 0=read
- req_addr  in  ADDR_W  start address
- req_beats  in  5  beat count; 0 treated as 1
- req_size  in  2  HSIZE code (byte/half/word)
- wdata  in  DATA_W  FIFO head (write data)
- wdata_valid  in  1  FIFO not empty
- wdata_pop  out  1  pop FIFO head this cycle
- rdata  out  DATA_W  read beat data (HRDATA passthrough)
- rdata_valid  out  1  read beat complete and OKAY
- done  out  1  one-cycle pulse, burst finished OKAY
- error  out  1  one-cycle pulse, burst aborted on HRESP
- busy  out  1  not IDLE
- HADDR  out  ADDR_W
- HTRANS  out  2
- HWRITE  out  1
- HSIZE  out  3
- HBURST  out  3
- HWDATA  out  DATA_W
- HRDATA  in  DATA_W
- HREADY  in  1
- HRESP  in  1

Behaviour:
- Reset (async, rst=1): state IDLE.
  - HTRANS=IDLE(00), HADDR=0, HWRITE=0, HSIZE=0, HBURST=0, HWDATA=0.
  - done=error=wdata_pop=rdata_valid=0; req_ready=1.
  - A reset mid-burst abandons the burst immediately; no done or error pulse.
- On acceptance, latch addr, write, size and beats (clamped to 1..MAX_BEATS).
- HBURST encoding: 1 beat→SINGLE(000), 4→INCR4(011), 8→INCR8(101), 16→INCR16(111), any other count→INCR(001).
- FSM states: IDLE, ADDR, DATA, ERR.
  - IDLE→ADDR: on accept. The next cycle drives HTRANS=NONSEQ with the latched controls.
  - ADDR: an address phase advances only at an edge where HREADY=1.
    - Beat n+1 (HTRANS=SEQ) is presented while beat n is in its data phase.
    - HADDR increments by (1<<size), 32-bit wrap.
    - After the last address phase is accepted, go to DATA with HTRANS=IDLE.
  - DATA: wait for the final data phase with HREADY=1, then pulse done and return to IDLE.
  - Any state with a data phase in flight: HRESP=1 && HREADY=0 (first error cycle) → drive HTRANS=IDLE that cycle, cancelling the remaining beats, and enter ERR.
  - ERR: wait for HREADY=1 (second error cycle), pulse error, go to IDLE. No done pulse.
- Write handshake:
  - wdata_pop = write && address phase active && HREADY.
  - HWDATA registers wdata on that edge, so it is valid during the matching data phase.
  - HWDATA holds while HREADY=0.
- Read handshake:
  - rdata_valid = read && data phase active && HREADY && !HRESP, combinational, zero latency; rdata = HRDATA.
- 1KB boundary crossing is the requester's responsibility; this block does not check or split it.
- A new request is never accepted in the same cycle as done or error; req_ready returns the following cycle.
- Without the optional feature, wdata_valid must be high whenever wdata_pop would assert; otherwise behaviour is undefined.

Optional Feature:
- Macro DMAC_AHB_BUSY_EN.
- Defined: during a write burst after NONSEQ, an address phase with wdata_valid=0 drives HTRANS=BUSY(01) with HADDR held and no pop. SEQ resumes when wdata_valid=1. BUSY is never driven on the first beat: NONSEQ waits in ADDR until wdata_valid=1.
- Undefined: wdata_valid is ignored and the HTRANS=BUSY encoding is never generated.

Test Plan:
- Single write: addr=0x1000, beats=1, size=word, HREADY=1 → HTRANS NONSEQ then IDLE, HBURST=000, HWDATA=FIFO word one cycle after the address phase, done pulses 2 cycles after accept.
- INCR4 read: addr=0x2000, HREADY low 2 cycles on beat 2 → HADDR 0x2000/04/08/0C, HADDR held during the stall, exactly 4 rdata_valid pulses, done once.
- 3-beat halfword write at 0x3002 → HBURST=001, HADDR 0x3002/0x3004/0x3006, 3 wdata_pop pulses.
- INCR16 write with HRESP error on beat 5 → HTRANS=IDLE in the first error cycle, error pulses once, done never, exactly 5 pops before the abort.
- Reset asserted mid-INCR8 → outputs at reset values in the same cycle, req_ready=1 after release.
- DMAC_AHB_BUSY_EN, wdata_valid low 3 cycles at beat 3 of INCR4 → 3 BUSY cycles with HADDR constant, then SEQ resumes and 4 beats complete.

Source files
------------

// File: rtl/dmac_ahb_master_if_if.sv
// Request, FIFO, status and AHB-Lite bus bundle for the DMA master port.
// The master modport is the DMA side; the slave modport is the bus/channel side.
interface dmac_ahb_master_if_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [4:0]        req_beats;
  logic [1:0]        req_size;
  logic [DATA_W-1:0] wdata;
  logic              wdata_valid;
  logic              wdata_pop;
  logic [DATA_W-1:0] rdata;
  logic              rdata_valid;
  logic              done;
  logic              error;
  logic              busy;
  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [2:0]        HBURST;
  logic [DATA_W-1:0] HWDATA;
  logic [DATA_W-1:0] HRDATA;
  logic              HREADY;
  logic              HRESP;

  modport master (
    input  req_valid, req_write, req_addr, req_beats, req_size,
    input  wdata, wdata_valid, HRDATA, HREADY, HRESP,
    output req_ready, wdata_pop, rdata, rdata_valid,
    output done, error, busy,
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA
  );

  modport slave (
    output req_valid, req_write, req_addr, req_beats, req_size,
    output wdata, wdata_valid, HRDATA, HREADY, HRESP,
    input  req_ready, wdata_pop, rdata, rdata_valid,
    input  done, error, busy,
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA
  );
endinterface

// File: rtl/dmac_ahb_master_if.sv
// AHB-Lite burst master for the DMA channel datapath.
// Define DMAC_AHB_BUSY_EN to insert HTRANS=BUSY while the write FIFO is empty.
module dmac_ahb_master_if #(
  parameter int MAX_BEATS = 16,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic clk,
  input  logic rst,
  dmac_ahb_master_if_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_ERR
  } state_t;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;
  localparam int         BW     = $clog2(MAX_BEATS + 1);

  state_t            state;
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [1:0]        hsize;
  logic [2:0]        hburst;
  logic [DATA_W-1:0] hwdata;
  logic [BW-1:0]     left;
  logic              dphase;
  logic              done_q;
  logic              error_q;

  logic [4:0]        beats_c;
  logic [2:0]        burst_c;
  logic [ADDR_W-1:0] inc;
  logic              accept;
  logic              aphase;
  logic              hold;
  logic [1:0]        hold_trans;
  logic              err1;
  logic              go;

  always_comb begin
    beats_c = bus.req_beats;
    if (beats_c == 5'd0)
      beats_c = 5'd1;
    else if (int'(beats_c) > MAX_BEATS)
      beats_c = 5'(MAX_BEATS);
  end

  always_comb begin
    unique case (beats_c)
      5'd1:    burst_c = 3'b000;
      5'd4:    burst_c = 3'b011;
      5'd8:    burst_c = 3'b101;
      5'd16:   burst_c = 3'b111;
      default: burst_c = 3'b001;
    endcase
  end

  assign inc    = ADDR_W'(1) << hsize;
  assign aphase = (state == S_ADDR);
  assign err1   = dphase && bus.HRESP && !bus.HREADY;

`ifdef DMAC_AHB_BUSY_EN
  localparam logic [1:0] T_BUSY = 2'b01;
  // An empty FIFO stalls the address phase: IDLE before the first beat, BUSY after.
  assign hold       = hwrite && !bus.wdata_valid && aphase;
  assign hold_trans = (htrans == T_NSEQ) ? T_IDLE : T_BUSY;
`else
  assign hold       = 1'b0;
  assign hold_trans = T_IDLE;
`endif

  assign go     = aphase && !hold && !err1 && bus.HREADY;
  assign accept = bus.req_valid && bus.req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      haddr   <= '0;
      htrans  <= T_IDLE;
      hwrite  <= 1'b0;
      hsize   <= 2'b00;
      hburst  <= 3'b000;
      hwdata  <= '0;
      left    <= '0;
      dphase  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            state  <= S_ADDR;
            haddr  <= bus.req_addr;
            htrans <= T_NSEQ;
            hwrite <= bus.req_write;
            hsize  <= bus.req_size;
            hburst <= burst_c;
            left   <= BW'(beats_c - 5'd1);
            dphase <= 1'b0;
          end
        end
        S_ADDR: begin
          if (err1) begin
            htrans <= T_IDLE;
            dphase <= 1'b0;
            state  <= S_ERR;
          end else if (bus.HREADY) begin
            dphase <= go;
            if (go) begin
              if (hwrite)
                hwdata <= bus.wdata;
              if (left == '0) begin
                htrans <= T_IDLE;
                state  <= S_DATA;
              end else begin
                haddr  <= haddr + inc;
                htrans <= T_SEQ;
                left   <= left - BW'(1);
              end
            end
          end
        end
        S_DATA: begin
          if (err1) begin
            dphase <= 1'b0;
            state  <= S_ERR;
          end else if (bus.HREADY) begin
            dphase <= 1'b0;
            done_q <= 1'b1;
            state  <= S_IDLE;
          end
        end
        S_ERR: begin
          if (bus.HREADY) begin
            error_q <= 1'b1;
            state   <= S_IDLE;
          end
        end
      endcase
    end
  end

  // First error cycle cancels the pending beat in the same cycle.
  always_comb begin
    bus.HTRANS = htrans;
    if (err1)
      bus.HTRANS = T_IDLE;
    else if (hold)
      bus.HTRANS = hold_trans;
  end

  assign bus.req_ready   = (state == S_IDLE) && !done_q && !error_q;
  assign bus.busy        = (state != S_IDLE);
  assign bus.done        = done_q;
  assign bus.error       = error_q;
  assign bus.wdata_pop   = hwrite && go;
  assign bus.rdata       = bus.HRDATA;
  assign bus.rdata_valid = !hwrite && dphase && bus.HREADY && !bus.HRESP;
  assign bus.HADDR       = haddr;
  assign bus.HWRITE      = hwrite;
  assign bus.HSIZE       = {1'b0, hsize};
  assign bus.HBURST      = hburst;
  assign bus.HWDATA      = hwdata;

endmodule

// File: tb/tb_dmac_ahb_master_if.sv
// Bench for dmac_ahb_master_if: directed bursts plus random bursts
// against an AHB slave/FIFO reference model.
module tb_dmac_ahb_master_if;

`ifdef DMAC_AHB_BUSY_EN
  localparam bit BUSY_EN = 1'b1;
`else
  localparam bit BUSY_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  dmac_ahb_master_if_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dmac_ahb_master_if #(
    .MAX_BEATS(16),
    .ADDR_W(32),
    .DATA_W(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int nbeats(input logic [4:0] b);
    if (b == 5'd0) return 1;
    if (b > 5'd16) return 16;
    return int'(b);
  endfunction

  function automatic logic [31:0] ea(input logic [31:0] a,
                                     input logic [1:0] sz, input int i);
    return a + (32'(i) << sz);
  endfunction

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5a5a_1234;
  endfunction

  task automatic idle_inputs();
    bus.req_valid   = 1'b0;
    bus.req_write   = 1'b0;
    bus.req_addr    = '0;
    bus.req_beats   = '0;
    bus.req_size    = '0;
    bus.wdata       = '0;
    bus.wdata_valid = 1'b1;
    bus.HRDATA      = '0;
    bus.HREADY      = 1'b1;
    bus.HRESP       = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_htrans"}, 64'(bus.HTRANS), 64'(0));
    chk({tag, "_haddr"}, 64'(bus.HADDR), 64'(0));
    chk({tag, "_ctrl"},
        64'({bus.HWRITE, bus.HSIZE, bus.HBURST}), 64'(0));
    chk({tag, "_hwdata"}, 64'(bus.HWDATA), 64'(0));
    chk({tag, "_pulses"},
        64'({bus.done, bus.error, bus.wdata_pop, bus.rdata_valid}),
        64'(0));
    chk({tag, "_rdy"}, 64'({bus.req_ready, bus.busy}), 64'(2'b10));
  endtask

  task automatic run_burst(input bit wr, input logic [31:0] a,
                           input logic [4:0] beats, input logic [1:0] sz,
                           input int err_beat, input int wait_pct,
                           input int stall_beat, input int stall_n,
                           input int vlow_beat, input int vlow_n,
                           input int vlow_pct);
    int nb, nx, xfers, pops, dones, errs, rvs, busys;
    int dp_idx, ephase, stall_left, vlow_left, wptr;
    bit dp, fin, xfer, e1, quiet, prev_hold;
    logic [31:0] prev_addr;
    logic [31:0] wq[$];
    logic [2:0] bexp;

    nb = nbeats(beats);
    case (nb)
      1:       bexp = 3'b000;
      4:       bexp = 3'b011;
      8:       bexp = 3'b101;
      16:      bexp = 3'b111;
      default: bexp = 3'b001;
    endcase
    wq.delete();
    for (int i = 0; i < nb; i++) wq.push_back($urandom);
    {xfers, pops, dones, errs, rvs, busys, dp_idx, ephase, wptr} = '0;
    dp = 0; fin = 0; prev_hold = 0; prev_addr = '0;
    stall_left = stall_n;
    vlow_left  = vlow_n;
    quiet = (wait_pct == 0 && stall_n == 0 && vlow_n == 0 &&
             vlow_pct == 0 && err_beat == 0);

    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_beats = beats;
    bus.req_size  = sz;
    bus.HREADY    = 1'b1;
    bus.HRESP     = 1'b0;
    #1 chk("req_ready", 64'(bus.req_ready), 64'(1));
    @(negedge clk);
    bus.req_valid = 1'b0;

    for (int k = 0; k < 400 && !fin; k++) begin
      e1 = 0;
      bus.HRESP  = 1'b0;
      bus.HREADY = 1'b1;
      if (ephase == 1) begin
        bus.HRESP = 1'b1;
        ephase = 2;
      end else if (ephase == 0 && dp && dp_idx + 1 == err_beat) begin
        bus.HREADY = 1'b0;
        bus.HRESP  = 1'b1;
        ephase = 1;
        e1 = 1;
      end else if (dp && dp_idx + 1 == stall_beat && stall_left > 0) begin
        bus.HREADY = 1'b0;
        stall_left--;
      end else if ($urandom_range(0, 99) < wait_pct) begin
        bus.HREADY = 1'b0;
      end
      bus.HRDATA = dp ? rd_word(ea(a, sz, dp_idx)) : $urandom;
      bus.wdata  = (wptr < nb) ? wq[wptr] : '0;
      bus.wdata_valid = 1'b1;
      if (BUSY_EN && wr && xfers == vlow_beat - 1 && vlow_left > 0) begin
        bus.wdata_valid = 1'b0;
        vlow_left--;
      end else if (BUSY_EN && wr && $urandom_range(0, 99) < vlow_pct) begin
        bus.wdata_valid = 1'b0;
      end

      #1;
      if (e1) chk("err_idle", 64'(bus.HTRANS), 64'(0));
      if (prev_hold) chk("addr_hold", 64'(bus.HADDR), 64'(prev_addr));
      xfer = bus.HREADY && bus.HTRANS[1];
      chk("pop", 64'(bus.wdata_pop), 64'(wr && xfer));
      chk("rvalid", 64'(bus.rdata_valid),
          64'(!wr && dp && bus.HREADY && !bus.HRESP));
      if (!wr && dp && bus.HREADY && !bus.HRESP) begin
        chk("rdata", 64'(bus.rdata), 64'(rd_word(ea(a, sz, dp_idx))));
        rvs++;
      end
      if (wr && dp && bus.HREADY && !bus.HRESP)
        chk("hwdata", 64'(bus.HWDATA), 64'(wq[dp_idx]));
      if (xfer) begin
        chk("haddr", 64'(bus.HADDR), 64'(ea(a, sz, xfers)));
        chk("htrans", 64'(bus.HTRANS), 64'(xfers == 0 ? 2'b10 : 2'b11));
        chk("ctrl", 64'({bus.HWRITE, bus.HSIZE, bus.HBURST}),
            64'({wr, 1'b0, sz, bexp}));
      end
      if (bus.HTRANS == 2'b01) begin
        busys++;
        chk("busy_addr", 64'(bus.HADDR), 64'(ea(a, sz, xfers)));
        chk("busy_first", 64'(xfers == 0), 64'(0));
      end
      if (bus.wdata_pop) begin
        pops++;
        wptr++;
      end
      if (bus.done || bus.error) begin
        dones += int'(bus.done);
        errs  += int'(bus.error);
        chk("rdy_at_end", 64'(bus.req_ready), 64'(0));
        if (quiet) chk("done_lat", 64'(k), 64'(nb + 1));
        fin = 1;
      end
      prev_hold = bus.HTRANS[1] && !bus.HREADY;
      prev_addr = bus.HADDR;

      @(posedge clk);
      if (bus.HREADY) begin
        dp = xfer;
        if (xfer) begin
          dp_idx = xfers;
          xfers++;
        end
      end
      @(negedge clk);
    end

    if (!fin) chk("timeout", 64'(0), 64'(1));
    nx = (err_beat != 0) ? err_beat : nb;
    chk("xfers", 64'(xfers), 64'(nx));
    chk("pops", 64'(pops), 64'(wr ? nx : 0));
    chk("rvalids", 64'(rvs),
        64'(wr ? 0 : ((err_beat != 0) ? err_beat - 1 : nb)));
    chk("dones", 64'(dones), 64'((err_beat != 0) ? 0 : 1));
    chk("errors", 64'(errs), 64'((err_beat != 0) ? 1 : 0));
    if (vlow_pct == 0)
      chk("busys", 64'(busys),
          64'((BUSY_EN && wr && vlow_beat > 1) ? vlow_n : 0));

    bus.HREADY = 1'b1;
    bus.HRESP  = 1'b0;
    #1;
    chk("rdy_after", 64'(bus.req_ready), 64'(1));
    chk("one_pulse", 64'({bus.done, bus.error}), 64'(0));
  endtask

  initial begin
    int nb, eb;
    logic [1:0] sz;
    logic [4:0] bt;
    checks   = 0;
    failures = 0;
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1 chk_reset_vals("rst_hold");
    rst = 1'b0;
    @(negedge clk);
    #1 chk_reset_vals("rst_rel");

    run_burst(1'b1, 32'h1000, 5'd1, 2'd2, 0, 0, 0, 0, 0, 0, 0);
    run_burst(1'b0, 32'h2000, 5'd4, 2'd2, 0, 0, 2, 2, 0, 0, 0);
    run_burst(1'b1, 32'h3002, 5'd3, 2'd1, 0, 0, 0, 0, 0, 0, 0);
    run_burst(1'b1, 32'h4000, 5'd16, 2'd2, 5, 0, 0, 0, 0, 0, 0);
    run_burst(1'b0, 32'h5000, 5'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0);
    run_burst(1'b0, 32'hFFFF_FFF8, 5'd20, 2'd2, 0, 0, 0, 0, 0, 0, 0);
    run_burst(1'b1, 32'h6000, 5'd4, 2'd2, 0, 0, 0, 0, 3, 3, 0);

    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'h7000;
    bus.req_beats = 5'd8;
    bus.req_size  = 2'd2;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk("busy_mid", 64'(bus.busy), 64'(1));
    rst = 1'b1;
    #1 chk_reset_vals("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk_reset_vals("rst_after");
      @(negedge clk);
    end

    for (int n = 0; n < 40; n++) begin
      sz = 2'($urandom_range(0, 2));
      bt = 5'($urandom_range(0, 20));
      nb = nbeats(bt);
      eb = ($urandom_range(0, 4) == 0) ? $urandom_range(1, nb) : 0;
      run_burst(1'($urandom_range(0, 1)), $urandom & ~((32'd1 << sz) - 1),
                bt, sz, eb, $urandom_range(0, 40), 0, 0, 0, 0,
                $urandom_range(0, 30));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
